// File: rtl/gray.sv
// gray -- WIDTH-bit Gray-code counter with a sticky wrap-around flag.
//
// A binary count is kept internally and advanced on every enabled rising
// edge of Clk. The reflected-binary Gray form of the next count is computed
// ahead of the edge and captured in its own register. Output is therefore a
// pure flop output and cannot glitch.
//
// Ports:
//   Clk      in   1      single clock, rising-edge active
//   Reset    in   1      asynchronous active-low reset (0 = reset)
//   En       in   1      count enable, sampled on the rising edge of Clk
//   Output   out  WIDTH  current count in Gray code, registered
//   Overflow out  1      sticky flag, set on an enabled wrap from the max count
module gray #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  output logic [WIDTH-1:0] Output,
  output logic             Overflow
);

  logic [WIDTH-1:0] bin_reg;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_reg;
  logic [WIDTH-1:0] gray_next;
  logic             ovf_reg;
  logic             ovf_next;
  logic             at_max;

  // All ones is the last binary value before the count wraps to zero.
  assign at_max = &bin_reg;

  always_comb begin
    bin_next = bin_reg;
    ovf_next = ovf_reg;
    if (En) begin
      bin_next = bin_reg + 1'b1;
      // Only an enabled step out of the maximum count can raise the flag.
      // Once set, the flag is never cleared here, so it stays set until reset.
      if (at_max) begin
        ovf_next = 1'b1;
      end
    end
  end

  // Gray encoding of the next count: each bit is the XOR of adjacent binary
  // bits, and the MSB passes through unchanged.
  assign gray_next[WIDTH-1] = bin_next[WIDTH-1];
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
      assign gray_next[gi] = bin_next[gi] ^ bin_next[gi+1];
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bin_reg  <= '0;
      gray_reg <= '0;
      ovf_reg  <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
      ovf_reg  <= ovf_next;
    end
  end

  assign Output   = gray_reg;
  assign Overflow = ovf_reg;

endmodule

// File: tb/tb_gray.sv
module tb_gray;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic [2:0] Output;
  logic       Overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic [2:0] out;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [2:0] out;
    logic       ovf;
    string      tag;
  } exp_t;

  exp_t sb[$];

  gray #(.WIDTH(3)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .En(En),
    .Output(Output),
    .Overflow(Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Watchdog: the run is clock-driven, but never let it hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] to_gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_now(input string tag, input logic [2:0] eo, input logic eov);
    checks++;
    if (Output !== eo || Overflow !== eov) begin
      errors++;
      $display("FAIL %s: got Output=%b Overflow=%b, required Output=%b Overflow=%b",
               tag, Output, Overflow, eo, eov);
    end else begin
      $display("ok   %s: Output=%b Overflow=%b", tag, Output, Overflow);
    end
  endtask

  // Called just after a falling edge: drive En, queue the expectation, and
  // compare against it 1 ns after the following rising edge.
  task automatic drive_edge(input logic en, input logic [2:0] eo, input logic eov,
                            input string tag);
    exp_t e;
    En = en;
    sb.push_back('{out: eo, ovf: eov, tag: tag});
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check_now(e.tag, e.out, e.ovf);
    @(negedge Clk);
  endtask

  vec_t vecs[17];

  initial begin
    logic [2:0] b;
    logic       ovf;
    logic [2:0] prev;
    exp_t       e;

    vecs[0]  = '{1'b1, 3'b001, 1'b0};
    vecs[1]  = '{1'b1, 3'b011, 1'b0};
    vecs[2]  = '{1'b0, 3'b011, 1'b0};
    vecs[3]  = '{1'b0, 3'b011, 1'b0};
    vecs[4]  = '{1'b0, 3'b011, 1'b0};
    vecs[5]  = '{1'b1, 3'b010, 1'b0};
    vecs[6]  = '{1'b1, 3'b110, 1'b0};
    vecs[7]  = '{1'b1, 3'b111, 1'b0};
    vecs[8]  = '{1'b1, 3'b101, 1'b0};
    vecs[9]  = '{1'b1, 3'b100, 1'b0};
    vecs[10] = '{1'b0, 3'b100, 1'b0};
    vecs[11] = '{1'b1, 3'b000, 1'b1};
    vecs[12] = '{1'b1, 3'b001, 1'b1};
    vecs[13] = '{1'b0, 3'b001, 1'b1};
    vecs[14] = '{1'b1, 3'b011, 1'b1};
    vecs[15] = '{1'b1, 3'b010, 1'b1};
    vecs[16] = '{1'b1, 3'b110, 1'b1};

    // Power-up hold: reset low from t=0, En raised at 10 ns, release at 110 ns.
    Reset = 1'b0;
    En    = 1'b0;
    @(negedge Clk);                         // t = 10
    for (int i = 0; i < 10; i++) begin
      drive_edge(1'b1, 3'b000, 1'b0, $sformatf("powerup_hold[%0d]", i));
    end
    // t = 110: release reset with En still high.
    Reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive_edge(vecs[i].en, vecs[i].out, vecs[i].ovf, $sformatf("vec[%0d]", i));
    end

    // Asynchronous reset between edges while Output=110 and Overflow=1.
    #2;
    Reset = 1'b0;
    #1;
    check_now("async_reset_immediate", 3'b000, 1'b0);
    @(negedge Clk);
    drive_edge(1'b1, 3'b000, 1'b0, "reset_hold_en[0]");
    drive_edge(1'b1, 3'b000, 1'b0, "reset_hold_en[1]");

    // First enabled edge after release gives 001.
    Reset = 1'b1;
    drive_edge(1'b1, 3'b001, 1'b0, "first_after_release");

    // Reset coinciding with an enabled edge resolves to the reset state.
    En = 1'b1;
    @(posedge Clk);
    Reset = 1'b0;
    #1;
    check_now("reset_on_enabled_edge", 3'b000, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;

    // Gray property across 24 enabled edges, with a reference binary model.
    b    = 3'b000;
    ovf  = 1'b0;
    prev = Output;
    En   = 1'b1;
    for (int i = 0; i < 24; i++) begin
      b = b + 3'd1;
      if (b == 3'b000) ovf = 1'b1;
      sb.push_back('{out: to_gray(b), ovf: ovf, tag: $sformatf("sweep[%0d]", i)});
      @(posedge Clk);
      #1;
      e = sb.pop_front();
      check_now(e.tag, e.out, e.ovf);
      checks++;
      if ($countones(prev ^ Output) != 1) begin
        errors++;
        $display("FAIL onebit[%0d]: %b -> %b changes %0d bits, required 1",
                 i, prev, Output, $countones(prev ^ Output));
      end else begin
        $display("ok   onebit[%0d]: %b -> %b", i, prev, Output);
      end
      prev = Output;
      @(negedge Clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
